// File: rtl/spm_pkg.sv
// Shared constants for the serial-parallel multiplier product path.
package spm_pkg;

    localparam int unsigned SPM_W  = 32;
    localparam int unsigned SPM_PW = 2 * SPM_W;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

endpackage

// File: rtl/spm_prod_fifo.sv
// Synchronous product FIFO; pointers carry an extra wrap bit so full and empty differ.
module spm_prod_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign count   = wptr - rptr;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr              <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/spm_product_collector.sv
// Assembles the LSB-first serial product stream into 2W-bit words and queues them.
module spm_product_collector
    import spm_pkg::*;
#(
    parameter int unsigned W     = SPM_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     bit_valid_i,
    input  logic                     bit_i,
    output logic                     prod_valid_o,
    input  logic                     prod_ready_i,
    output logic [2*W-1:0]           prod_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     clr_ovf_i
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(PW) + 1;
    localparam logic [CW-1:0] LAST    = CW'(PW - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t          state;
    logic [CW-1:0]   cnt;
    // Only the upper 2W-1 bits are kept: the oldest bit falls out on the final shift.
    logic [PW-2:0]   sr;
    logic            first_bit;
    logic            next_bit;
    logic            push;
    logic            empty;
    logic            drop;
    logic [PW-1:0]   word;

    assign first_bit = bit_valid_i && start_i;
    assign next_bit  = bit_valid_i && !start_i && (state == SHIFT);
    assign push      = next_bit && (cnt == LAST);
    assign word      = {bit_i, sr};
    assign busy_o    = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else if (first_bit) begin
            state <= SHIFT;
            cnt   <= CNT_ONE;
            sr    <= {bit_i, sr[PW-2:1]};
        end else if (next_bit) begin
            sr <= {bit_i, sr[PW-2:1]};
            if (push) begin
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_o <= 1'b0;
        end
    end

    spm_prod_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (word),
        .pop   (prod_ready_i),
        .dout  (prod_o),
        .empty (empty),
        .count (count_o),
        .drop  (drop)
    );

    assign prod_valid_o = !empty;

endmodule

// File: tb/tb_spm_product_collector.sv
// Directed bench for the product collector at W=32, DEPTH=2.
module tb_spm_product_collector;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          bit_valid_i = 1'b0;
    logic          bit_i = 1'b0;
    logic          prod_ready_i = 1'b0;
    logic          clr_ovf_i = 1'b0;
    logic          prod_valid_o;
    logic [63:0]   prod_o;
    logic          busy_o;
    logic [1:0]    count_o;
    logic          overflow_o;

    int passes = 0;
    int total  = 0;

    spm_product_collector #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .bit_valid_i  (bit_valid_i),
        .bit_i        (bit_i),
        .prod_valid_o (prod_valid_o),
        .prod_ready_i (prod_ready_i),
        .prod_o       (prod_o),
        .busy_o       (busy_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .clr_ovf_i    (clr_ovf_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        prod_ready_i = 1'b1;
        tick();
        prod_ready_i = 1'b0;
    endtask

    // Sends bits lo..hi of w; bit 0 carries start_i. Optional idle gap before every third bit.
    task automatic send_bits(input logic [63:0] w, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && (i % 3 == 2)) begin
                bit_valid_i = 1'b0;
                start_i     = 1'b0;
                tick();
                chk("busy_gap", 64'(busy_o), 64'd1);
            end
            bit_valid_i = 1'b1;
            bit_i       = w[i];
            start_i     = (i == 0);
            tick();
        end
        bit_valid_i = 1'b0;
        start_i     = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(prod_valid_o), 64'd0);
        chk("rst_prod",  prod_o,            64'd0);
        chk("rst_busy",  64'(busy_o),       64'd0);
        chk("rst_count", 64'(count_o),      64'd0);
        chk("rst_ovf",   64'(overflow_o),   64'd0);
        rst = 1'b0;
        tick();

        // Product 15, latency of the final bit
        send_bits(64'hF, 0, 62, 1'b0);
        chk("p15_busy_pre",  64'(busy_o),       64'd1);
        chk("p15_valid_pre", 64'(prod_valid_o), 64'd0);
        send_bits(64'hF, 63, 63, 1'b0);
        chk("p15_valid", 64'(prod_valid_o), 64'd1);
        chk("p15_prod",  prod_o,            64'h0000_0000_0000_000F);
        chk("p15_count", 64'(count_o),      64'd1);
        chk("p15_busy",  64'(busy_o),       64'd0);
        pop_one();
        chk("p15_pop_valid", 64'(prod_valid_o), 64'd0);
        chk("p15_pop_count", 64'(count_o),      64'd0);

        // 0xFFFFFFFF squared with strobe gaps
        send_bits(64'hFFFF_FFFE_0000_0001, 0, 63, 1'b1);
        chk("sq_prod",  prod_o,       64'hFFFF_FFFE_0000_0001);
        chk("sq_count", 64'(count_o), 64'd1);
        pop_one();

        // Three back-to-back products, no consumer
        send_bits(64'h1111_2222_3333_4444, 0, 63, 1'b0);
        send_bits(64'hAAAA_BBBB_CCCC_DDDD, 0, 63, 1'b0);
        chk("bb_ovf_pre", 64'(overflow_o), 64'd0);
        send_bits(64'h0123_4567_89AB_CDEF, 0, 63, 1'b0);
        chk("bb_count", 64'(count_o),    64'd2);
        chk("bb_ovf",   64'(overflow_o), 64'd1);
        chk("bb_head0", prod_o,          64'h1111_2222_3333_4444);
        pop_one();
        chk("bb_head1",  prod_o,       64'hAAAA_BBBB_CCCC_DDDD);
        chk("bb_count1", 64'(count_o), 64'd1);
        pop_one();
        chk("bb_count0", 64'(count_o),      64'd0);
        chk("bb_valid0", 64'(prod_valid_o), 64'd0);
        chk("bb_ovf_kept", 64'(overflow_o), 64'd1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        chk("bb_ovf_clr", 64'(overflow_o), 64'd0);

        // Full FIFO: final bit coincides with a pop
        send_bits(64'h0D0D_0D0D_0D0D_0D0D, 0, 63, 1'b0);
        send_bits(64'h0E0E_0E0E_0E0E_0E0E, 0, 63, 1'b0);
        send_bits(64'hF0F0_F0F0_1234_5678, 0, 62, 1'b0);
        prod_ready_i = 1'b1;
        send_bits(64'hF0F0_F0F0_1234_5678, 63, 63, 1'b0);
        prod_ready_i = 1'b0;
        chk("pp_count", 64'(count_o),    64'd2);
        chk("pp_ovf",   64'(overflow_o), 64'd0);
        chk("pp_head",  prod_o,          64'h0E0E_0E0E_0E0E_0E0E);
        pop_one();
        chk("pp_head2", prod_o, 64'hF0F0_F0F0_1234_5678);
        pop_one();
        chk("pp_empty", 64'(count_o), 64'd0);

        // Restart after 20 bits discards the partial word
        send_bits(64'hDEAD_BEEF_CAFE_F00D, 0, 19, 1'b0);
        send_bits(64'h1234, 0, 62, 1'b0);
        chk("rs_count_pre", 64'(count_o), 64'd0);
        send_bits(64'h1234, 63, 63, 1'b0);
        chk("rs_count", 64'(count_o),    64'd1);
        chk("rs_prod",  prod_o,          64'h1234);
        chk("rs_ovf",   64'(overflow_o), 64'd0);
        pop_one();

        // Asynchronous reset mid-assembly with a word queued
        send_bits(64'h5555_6666_7777_8888, 0, 63, 1'b0);
        send_bits(64'h9999_AAAA_BBBB_CCCC, 0, 39, 1'b0);
        chk("ar_count_pre", 64'(count_o), 64'd1);
        chk("ar_busy_pre",  64'(busy_o),  64'd1);
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(prod_valid_o), 64'd0);
        chk("ar_prod",  prod_o,            64'd0);
        chk("ar_busy",  64'(busy_o),       64'd0);
        chk("ar_count", 64'(count_o),      64'd0);
        chk("ar_ovf",   64'(overflow_o),   64'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 64; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = 1'b1;
            start_i     = 1'b0;
            tick();
        end
        bit_valid_i = 1'b0;
        chk("ns_busy",  64'(busy_o),  64'd0);
        chk("ns_count", 64'(count_o), 64'd0);
        send_bits(64'h7, 0, 63, 1'b0);
        chk("ns_after_prod",  prod_o,       64'h7);
        chk("ns_after_count", 64'(count_o), 64'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
